// File: rtl/dp_exec_stage.sv
// ARM data-processing execute stage: ALU + NZCV register feeding a 2-entry result queue.
// Result visible one cycle after accept; in_ready = queue not full (registered), out_* held while stalled.
module dp_exec_stage #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         opcode,
  input  logic               s_bit,
  input  logic [DATA_W-1:0]  rn,
  input  logic [DATA_W-1:0]  op2,
  input  logic               shift_carry,
  input  logic [RADDR_W-1:0] rd_addr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_result,
  output logic [RADDR_W-1:0] out_rd_addr,
  output logic               out_we,
  output logic [3:0]         flags
);

  typedef struct packed {
    logic               we;
    logic [RADDR_W-1:0] rd;
    logic [DATA_W-1:0]  res;
  } entry_t;

  entry_t      q_mem_q [2];
  entry_t      q_mem_d [2];
  logic [1:0]  count_q, count_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [3:0]  flags_q, flags_d;

  logic [DATA_W-1:0] add_a, add_b, alu_res;
  logic              add_cin, is_arith, is_cmp, upd, push, pop;
  logic [DATA_W:0]   sum;
  logic              ovf;
  entry_t            new_entry;
  entry_t            head;

  // Subtracts are expressed as a + ~b + cin so one adder covers every arithmetic opcode.
  always_comb begin
    add_a    = rn;
    add_b    = op2;
    add_cin  = 1'b0;
    is_arith = 1'b1;
    case (opcode)
      4'h2, 4'hA: begin add_b = ~op2; add_cin = 1'b1; end
      4'h3:       begin add_a = op2; add_b = ~rn; add_cin = 1'b1; end
      4'h4, 4'hB: ;
      4'h5:       add_cin = flags_q[1];
      4'h6:       begin add_b = ~op2; add_cin = flags_q[1]; end
      4'h7:       begin add_a = op2; add_b = ~rn; add_cin = flags_q[1]; end
      default:    is_arith = 1'b0;
    endcase
  end

  assign sum = {1'b0, add_a} + {1'b0, add_b} + {{DATA_W{1'b0}}, add_cin};
  assign ovf = (add_a[DATA_W-1] == add_b[DATA_W-1]) && (sum[DATA_W-1] != add_a[DATA_W-1]);

  always_comb begin
    alu_res = sum[DATA_W-1:0];
    case (opcode)
      4'h0, 4'h8: alu_res = rn & op2;
      4'h1, 4'h9: alu_res = rn ^ op2;
      4'hC:       alu_res = rn | op2;
      4'hD:       alu_res = op2;
      4'hE:       alu_res = rn & ~op2;
      4'hF:       alu_res = ~op2;
      default:    alu_res = sum[DATA_W-1:0];
    endcase
  end

  assign is_cmp    = (opcode[3:2] == 2'b10);
  assign upd       = s_bit | is_cmp;
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    new_entry.we  = ~is_cmp;
    new_entry.rd  = rd_addr;
    new_entry.res = alu_res;
  end

  always_comb begin
    q_mem_d[0] = q_mem_q[0];
    q_mem_d[1] = q_mem_q[1];
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    flags_d    = flags_q;
    if (push) begin
      q_mem_d[wr_ptr_q] = new_entry;
      wr_ptr_d          = ~wr_ptr_q;
      if (upd) begin
        flags_d[3] = alu_res[DATA_W-1];
        flags_d[2] = (alu_res == '0);
        flags_d[1] = is_arith ? sum[DATA_W] : shift_carry;
        flags_d[0] = is_arith ? ovf : flags_q[0];
      end
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    // With one entry, a concurrent push and pop leaves the new entry as head.
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_mem_q[0] <= '0;
      q_mem_q[1] <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      flags_q    <= 4'b0000;
    end else begin
      q_mem_q[0] <= q_mem_d[0];
      q_mem_q[1] <= q_mem_d[1];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      flags_q    <= flags_d;
    end
  end

  assign head        = q_mem_q[rd_ptr_q];
  assign out_result  = head.res;
  assign out_rd_addr = head.rd;
  assign out_we      = head.we;
  assign flags       = flags_q;

endmodule
